// File: rtl/rpc_pkg.sv
// Shared types for the setget_pixel RPC arbiter.
// Holds the FSM state encoding and an index-width helper.
package rpc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETURN = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority pick.
// Returns the first set req bit at or after ptr, wrapping.
module rr_pick
    import rpc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rpc_pixel_arbiter.sv
// N-client round-robin front end for one setget_pixel server.
// Four-phase req/ack on both sides, with an abort watchdog.
module rpc_pixel_arbiter
    import rpc_pkg::*;
#(
    parameter int             N_CLIENTS = 4,
    parameter int             AW        = 32,
    parameter int             DW        = 8,
    parameter int             TIMEOUT   = 1024,
    parameter logic [DW-1:0]  ERR_DATA  = {DW{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CLIENTS-1:0]    cli_req,
    output logic [N_CLIENTS-1:0]    cli_ack,
    input  logic [N_CLIENTS*AW-1:0] cli_axx,
    input  logic [N_CLIENTS*AW-1:0] cli_ayy,
    input  logic [N_CLIENTS-1:0]    cli_readf,
    input  logic [N_CLIENTS*DW-1:0] cli_wdata,
    output logic [DW-1:0]           cli_return,
    output logic                    srv_req,
    input  logic                    srv_ack,
    output logic [AW-1:0]           srv_axx,
    output logic [AW-1:0]           srv_ayy,
    output logic                    srv_readf,
    output logic [DW-1:0]           srv_wdata,
    input  logic [DW-1:0]           srv_return,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int IW    = idx_w(N_CLIENTS);
    localparam int CW    = idx_w(TIMEOUT);
    localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [N_CLIENTS-1:0] ONE = {{(N_CLIENTS-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [AW-1:0]          axx_q, axx_d;
    logic [AW-1:0]          ayy_q, ayy_d;
    logic                   readf_q, readf_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          ret_q, ret_d;
    logic [N_CLIENTS-1:0]   ack_q, ack_d;
    logic                   sreq_q, sreq_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   terr_q, terr_d;

    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    rr_pick #(
        .N  (N_CLIENTS),
        .IW (IW)
    ) u_pick (
        .req (cli_req),
        .ptr (rr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        axx_d   = axx_q;
        ayy_d   = ayy_q;
        readf_d = readf_q;
        wdata_d = wdata_q;
        ret_d   = ret_q;
        ack_d   = ack_q;
        sreq_d  = sreq_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    axx_d   = cli_axx[pick_idx*AW +: AW];
                    ayy_d   = cli_ayy[pick_idx*AW +: AW];
                    readf_d = cli_readf[pick_idx];
                    wdata_d = cli_wdata[pick_idx*DW +: DW];
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Only an ack to a request we actually raised is honoured.
                if (sreq_q && srv_ack) begin
                    ret_d   = srv_return;
                    sreq_d  = 1'b0;
                    ack_d   = ONE << gnt_q;
                    state_d = RETURN;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TO_M1)) begin
                    ret_d   = ERR_DATA;
                    sreq_d  = 1'b0;
                    terr_d  = 1'b1;
                    ack_d   = ONE << gnt_q;
                    state_d = RETURN;
                end else begin
                    sreq_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            RETURN: begin
                // Waiting on srv_ack low also swallows a late ack after an abort.
                if (!cli_req[gnt_q] && !srv_ack) begin
                    ack_d   = '0;
                    rr_d    = (gnt_q == IW'(N_CLIENTS - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            axx_q   <= '0;
            ayy_q   <= '0;
            readf_q <= 1'b0;
            wdata_q <= '0;
            ret_q   <= '0;
            ack_q   <= '0;
            sreq_q  <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            axx_q   <= axx_d;
            ayy_q   <= ayy_d;
            readf_q <= readf_d;
            wdata_q <= wdata_d;
            ret_q   <= ret_d;
            ack_q   <= ack_d;
            sreq_q  <= sreq_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign cli_ack     = ack_q;
    assign cli_return  = ret_q;
    assign srv_req     = sreq_q;
    assign srv_axx     = axx_q;
    assign srv_ayy     = ayy_q;
    assign srv_readf   = readf_q;
    assign srv_wdata   = wdata_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rpc_pixel_arbiter.sv
// Directed bench for rpc_pixel_arbiter, 4 clients, TIMEOUT=16.
// Inputs driven and outputs sampled on the falling edge.
module tb_rpc_pixel_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cli_req;
    logic [N-1:0]    cli_ack;
    logic [N*AW-1:0] cli_axx;
    logic [N*AW-1:0] cli_ayy;
    logic [N-1:0]    cli_readf;
    logic [N*DW-1:0] cli_wdata;
    logic [DW-1:0]   cli_return;
    logic            srv_req;
    logic            srv_ack;
    logic [AW-1:0]   srv_axx;
    logic [AW-1:0]   srv_ayy;
    logic            srv_readf;
    logic [DW-1:0]   srv_wdata;
    logic [DW-1:0]   srv_return;
    logic            timeout_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpc_pixel_arbiter #(
        .N_CLIENTS (N),
        .AW        (AW),
        .DW        (DW),
        .TIMEOUT   (16),
        .ERR_DATA  (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cli_req     (cli_req),
        .cli_ack     (cli_ack),
        .cli_axx     (cli_axx),
        .cli_ayy     (cli_ayy),
        .cli_readf   (cli_readf),
        .cli_wdata   (cli_wdata),
        .cli_return  (cli_return),
        .srv_req     (srv_req),
        .srv_ack     (srv_ack),
        .srv_axx     (srv_axx),
        .srv_ayy     (srv_ayy),
        .srv_readf   (srv_readf),
        .srv_wdata   (srv_wdata),
        .srv_return  (srv_return),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic set_cli(input int i, input logic [31:0] x,
                           input logic [31:0] y, input logic rd,
                           input logic [7:0] wd);
        cli_axx[i*AW +: AW] = x;
        cli_ayy[i*AW +: AW] = y;
        cli_readf[i]        = rd;
        cli_wdata[i*DW +: DW] = wd;
    endtask

    // Serve one call: ack when srv_req is seen, then release the granted client.
    task automatic do_txn(input logic [7:0] rv,
                          output logic [N-1:0] ackv,
                          output logic [7:0] retv);
        int t;
        ackv = '0;
        retv = '0;
        t = 0;
        while (srv_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (srv_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL txn_srv_req: srv_req=%b after %0d cycles, want 1", srv_req, t);
        end
        srv_return = rv;
        srv_ack    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (cli_ack === '0 && t < 100);
        if (cli_ack === '0) begin
            checks++;
            errors++;
            $display("FAIL txn_cli_ack: cli_ack=%b after %0d cycles, want nonzero", cli_ack, t);
        end
        ackv    = cli_ack;
        retv    = cli_return;
        cli_req = cli_req & ~cli_ack;
        srv_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        cli_req    = '0;
        cli_axx    = '0;
        cli_ayy    = '0;
        cli_readf  = '0;
        cli_wdata  = '0;
        srv_ack    = 1'b0;
        srv_return = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({srv_req, cli_ack, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b ack=%b busy=%b terr=%b want all 0",
                     srv_req, cli_ack, busy, timeout_err);
        end
        checks++;
        if ({cli_return, srv_axx, srv_wdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: ret=%h axx=%h wd=%h want 0",
                     cli_return, srv_axx, srv_wdata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write;
        set_cli(2, 32'd3, 32'd5, 1'b0, 8'h5A);
        cli_req[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (srv_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_grant: srv_req=%b busy=%b want 0 1", srv_req, busy);
        end
        @(negedge clk);
        checks++;
        if (srv_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_srv_req: srv_req=%b want 1", srv_req);
        end
        checks++;
        if (srv_axx !== 32'd3 || srv_ayy !== 32'd5 ||
            srv_wdata !== 8'h5A || srv_readf !== 1'b0) begin
            errors++;
            $display("FAIL wr_args: axx=%0d ayy=%0d wd=%h rd=%b want 3 5 5a 0",
                     srv_axx, srv_ayy, srv_wdata, srv_readf);
        end
        srv_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (cli_ack !== 4'b0100 || srv_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: cli_ack=%b srv_req=%b want 0100 0", cli_ack, srv_req);
        end
        cli_req[2] = 1'b0;
        srv_ack    = 1'b0;
        @(negedge clk);
        checks++;
        if (cli_ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_release: cli_ack=%b busy=%b want 0000 0", cli_ack, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] a;
        logic [7:0]   r;
        logic [N-1:0] exp_q[$];
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) set_cli(i, 32'(i), 32'(i), 1'b0, 8'(i));
        cli_req = 4'b1111;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            do_txn(8'h00, a, r);
            checks++;
            if (a !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_all[%0d]: cli_ack=%b want %b", i, a, exp_q[i]);
            end
        end
        cli_req = 4'b0011;
        do_txn(8'h00, a, r);
        checks++;
        if (a !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap0: cli_ack=%b want 0001", a);
        end
        cli_req[0] = 1'b1;
        exp_q = '{4'b0010, 4'b0001};
        for (int i = 0; i < 2; i++) begin
            do_txn(8'h00, a, r);
            checks++;
            if (a !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_adv[%0d]: cli_ack=%b want %b", i, a, exp_q[i]);
            end
        end
    endtask

    task automatic test_read_return;
        int t;
        set_cli(1, 32'd7, 32'd9, 1'b1, 8'h00);
        cli_req[1] = 1'b1;
        t = 0;
        while (srv_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (srv_req !== 1'b1 || srv_readf !== 1'b1) begin
            errors++;
            $display("FAIL rd_issue: srv_req=%b readf=%b want 1 1", srv_req, srv_readf);
        end
        srv_return = 8'hC3;
        srv_ack    = 1'b1;
        @(negedge clk);
        srv_return = 8'h00;
        checks++;
        if (cli_ack !== 4'b0010 || cli_return !== 8'hC3) begin
            errors++;
            $display("FAIL rd_return: ack=%b ret=%h want 0010 c3", cli_ack, cli_return);
        end
        @(negedge clk);
        checks++;
        if (cli_ack !== 4'b0010 || cli_return !== 8'hC3) begin
            errors++;
            $display("FAIL rd_hold: ack=%b ret=%h want 0010 c3", cli_ack, cli_return);
        end
        cli_req[1] = 1'b0;
        srv_ack    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        logic [N-1:0] a;
        logic [7:0]   r;
        set_cli(3, 32'd1, 32'd2, 1'b0, 8'h77);
        cli_req[3] = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (srv_req !== 1'b1 || cli_ack !== 4'b0000) begin
            errors++;
            $display("FAIL to_wait: srv_req=%b ack=%b want 1 0000", srv_req, cli_ack);
        end
        @(negedge clk);
        checks++;
        if (srv_req !== 1'b0 || cli_ack !== 4'b1000 ||
            cli_return !== 8'hFF || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_abort: req=%b ack=%b ret=%h terr=%b want 0 1000 ff 1",
                     srv_req, cli_ack, cli_return, timeout_err);
        end
        srv_ack = 1'b1;
        @(negedge clk);
        cli_req[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (cli_ack !== 4'b1000 || srv_req !== 1'b0) begin
            errors++;
            $display("FAIL to_late_ack: ack=%b srv_req=%b want 1000 0", cli_ack, srv_req);
        end
        srv_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (cli_ack !== 4'b0000 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: ack=%b terr=%b want 0000 1", cli_ack, timeout_err);
        end
        cli_req[0] = 1'b1;
        do_txn(8'h11, a, r);
        checks++;
        if (a !== 4'b0001 || r !== 8'h11 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_recover: ack=%b ret=%h terr=%b want 0001 11 1",
                     a, r, timeout_err);
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] a;
        logic [7:0]   r;
        int t;
        cli_req = 4'b0101;
        t = 0;
        while (srv_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (srv_req !== 1'b1 || srv_axx !== 32'd2) begin
            errors++;
            $display("FAIL rst_pre: srv_req=%b axx=%0d want 1 2", srv_req, srv_axx);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({srv_req, cli_ack, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid: req=%b ack=%b busy=%b terr=%b want all 0",
                     srv_req, cli_ack, busy, timeout_err);
        end
        @(negedge clk);
        reset = 1'b1;
        do_txn(8'h22, a, r);
        checks++;
        if (a !== 4'b0001) begin
            errors++;
            $display("FAIL rst_regrant0: ack=%b want 0001", a);
        end
        do_txn(8'h33, a, r);
        checks++;
        if (a !== 4'b0100) begin
            errors++;
            $display("FAIL rst_regrant2: ack=%b want 0100", a);
        end
    endtask

    task automatic test_arg_hold;
        logic [N-1:0] a;
        logic [7:0]   r;
        int t;
        set_cli(3, 32'd100, 32'd200, 1'b0, 8'h44);
        cli_req[3] = 1'b1;
        @(negedge clk);
        set_cli(3, 32'd999, 32'd888, 1'b1, 8'h99);
        t = 0;
        while (srv_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (srv_req !== 1'b1 || srv_axx !== 32'd100 || srv_ayy !== 32'd200 ||
                srv_wdata !== 8'h44 || srv_readf !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: req=%b axx=%0d ayy=%0d wd=%h rd=%b want 1 100 200 44 0",
                         i, srv_req, srv_axx, srv_ayy, srv_wdata, srv_readf);
            end
            cli_axx[3*AW +: AW] = 32'(1000 + i);
            @(negedge clk);
        end
        do_txn(8'h55, a, r);
        checks++;
        if (a !== 4'b1000 || r !== 8'h55) begin
            errors++;
            $display("FAIL hold_done: ack=%b ret=%h want 1000 55", a, r);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_return();
        test_timeout();
        test_reset_mid();
        test_arg_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
